// File: rtl/can_tx_mailbox_arbiter_if.sv
// Signal bundle between the host/bit-engine side and can_tx_mailbox_arbiter.
// The arbiter uses the slave modport; the host/bit-engine side uses master.
interface can_tx_mailbox_arbiter_if #(
  parameter int unsigned NUM_MB = 4
);
  logic [NUM_MB-1:0] mb_load;
  logic [10:0]       mb_id_in;
  logic [63:0]       mb_data_in;
  logic [NUM_MB-1:0] mb_abort;
  logic              bus_idle;
  logic              tx_start;
  logic [10:0]       tx_id;
  logic [63:0]       tx_data;
  logic              tx_done;
  logic              tx_arb_lost;
  logic              tx_err;
  logic [NUM_MB-1:0] mb_pending;
  logic [NUM_MB-1:0] mb_done;
  logic [NUM_MB-1:0] mb_fail;
  logic              busy;

  modport master (
    output mb_load, mb_id_in, mb_data_in, mb_abort, bus_idle,
           tx_done, tx_arb_lost, tx_err,
    input  tx_start, tx_id, tx_data, mb_pending, mb_done, mb_fail, busy
  );

  modport slave (
    input  mb_load, mb_id_in, mb_data_in, mb_abort, bus_idle,
           tx_done, tx_arb_lost, tx_err,
    output tx_start, tx_id, tx_data, mb_pending, mb_done, mb_fail, busy
  );
endinterface

// File: rtl/can_tx_mailbox_arbiter.sv
// CAN TX mailbox arbiter: lowest-ID pending mailbox is launched after the interframe space.
// Define CAN_TX_ARB_SINGLE_SHOT_EN for one-shot mode (any error or lost arbitration drops the frame).
module can_tx_mailbox_arbiter #(
  parameter int unsigned NUM_MB    = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned IFS_WAIT  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  can_tx_mailbox_arbiter_if.slave bus
);
  localparam int unsigned IW = $clog2(NUM_MB);
  localparam int unsigned CW = $clog2(IFS_WAIT + 2);
  localparam logic [CW-1:0] IFS_MAX = CW'(IFS_WAIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_WAIT_BUS,
    S_START,
    S_BUSY
  } state_t;

  state_t            state;
  logic [IW-1:0]     sel;
  logic [CW-1:0]     idle_cnt;
  logic [CW-1:0]     idle_inc;
  logic [NUM_MB-1:0] pending;
  logic [NUM_MB-1:0] done_q;
  logic [NUM_MB-1:0] fail_q;
  logic [10:0]       id_q   [NUM_MB];
  logic [63:0]       data_q [NUM_MB];
  logic              tx_start_q;
  logic              busy_q;
  logic [10:0]       tx_id_q;
  logic [63:0]       tx_data_q;
`ifndef CAN_TX_ARB_SINGLE_SHOT_EN
  logic [3:0]        retry [NUM_MB];
  logic [3:0]        retry_inc;
  assign retry_inc = retry[sel] + 4'd1;
`endif

  logic              found;
  logic [IW-1:0]     win;
  logic [10:0]       win_id;
  logic              load_any;
  logic [IW-1:0]     load_idx;
  logic [NUM_MB-1:0] locked;
  logic              frozen;

  // Strict less-than keeps the lowest index on an ID tie.
  always_comb begin
    found  = 1'b0;
    win    = '0;
    win_id = '1;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (pending[i] && (!found || id_q[i] < win_id)) begin
        found  = 1'b1;
        win    = IW'(i);
        win_id = id_q[i];
      end
    end
  end

  always_comb begin
    load_any = 1'b0;
    load_idx = '0;
    for (int unsigned i = 0; i < NUM_MB; i++) begin
      if (bus.mb_load[i] && !load_any) begin
        load_any = 1'b1;
        load_idx = IW'(i);
      end
    end
  end

  assign locked   = (state == S_WAIT_BUS || state == S_START || state == S_BUSY)
                    ? (NUM_MB'(1) << sel) : '0;
  assign frozen   = (state == S_START || state == S_BUSY);
  assign idle_inc = (idle_cnt == IFS_MAX) ? idle_cnt : idle_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sel        <= '0;
      idle_cnt   <= '0;
      pending    <= '0;
      done_q     <= '0;
      fail_q     <= '0;
      tx_start_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_id_q    <= '0;
      tx_data_q  <= '0;
      for (int unsigned i = 0; i < NUM_MB; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
`ifndef CAN_TX_ARB_SINGLE_SHOT_EN
        retry[i]  <= '0;
`endif
      end
    end else begin
      done_q     <= '0;
      fail_q     <= '0;
      tx_start_q <= 1'b0;

      if (load_any && !locked[load_idx]) begin
        id_q[load_idx]    <= bus.mb_id_in;
        data_q[load_idx]  <= bus.mb_data_in;
        pending[load_idx] <= 1'b1;
`ifndef CAN_TX_ARB_SINGLE_SHOT_EN
        retry[load_idx]   <= '0;
`endif
      end

      // Issued after the load so that abort wins on the same mailbox.
      for (int unsigned i = 0; i < NUM_MB; i++) begin
        if (bus.mb_abort[i] && !(locked[i] && frozen)) begin
          pending[i] <= 1'b0;
`ifndef CAN_TX_ARB_SINGLE_SHOT_EN
          retry[i]   <= '0;
`endif
        end
      end

      unique case (state)
        S_IDLE: begin
          if (|pending) begin
            state  <= S_SELECT;
            busy_q <= 1'b1;
          end
        end
        S_SELECT: begin
          if (found) begin
            sel       <= win;
            tx_id_q   <= id_q[win];
            tx_data_q <= data_q[win];
            idle_cnt  <= '0;
            state     <= S_WAIT_BUS;
          end else begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end
        S_WAIT_BUS: begin
          // The locked frame may have been aborted during SELECT as well.
          if (bus.mb_abort[sel] || !pending[sel]) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end else if (bus.bus_idle) begin
            idle_cnt <= idle_inc;
            if (idle_inc >= IFS_MAX) begin
              state      <= S_START;
              tx_start_q <= 1'b1;
            end
          end else begin
            idle_cnt <= '0;
          end
        end
        S_START: begin
          state <= S_BUSY;
        end
        S_BUSY: begin
          if (bus.tx_done) begin
            pending[sel] <= 1'b0;
            done_q[sel]  <= 1'b1;
`ifndef CAN_TX_ARB_SINGLE_SHOT_EN
            retry[sel]   <= '0;
`endif
            state        <= S_IDLE;
            busy_q       <= 1'b0;
          end else if (bus.tx_err || bus.tx_arb_lost) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
`ifdef CAN_TX_ARB_SINGLE_SHOT_EN
            pending[sel] <= 1'b0;
            fail_q[sel]  <= 1'b1;
`else
            if (bus.tx_err) begin
              if (retry_inc == 4'(MAX_RETRY)) begin
                pending[sel] <= 1'b0;
                retry[sel]   <= '0;
                fail_q[sel]  <= 1'b1;
              end else begin
                retry[sel] <= retry_inc;
              end
            end
`endif
          end
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tx_start   = tx_start_q;
  assign bus.tx_id      = tx_id_q;
  assign bus.tx_data    = tx_data_q;
  assign bus.mb_pending = pending;
  assign bus.mb_done    = done_q;
  assign bus.mb_fail    = fail_q;
  assign bus.busy       = busy_q;

endmodule

// File: tb/tb_can_tx_mailbox_arbiter.sv
// Bench for can_tx_mailbox_arbiter: directed scenarios plus randomized traffic against a
// mailbox-level reference model. Honours CAN_TX_ARB_SINGLE_SHOT_EN like the design.
module tb_can_tx_mailbox_arbiter;
  localparam int NMB = 4;
  localparam int MR  = 3;
  localparam int IFS = 3;

  localparam int ST_IDLE  = 0;
  localparam int ST_SEL   = 1;
  localparam int ST_WAIT  = 2;
  localparam int ST_START = 3;
  localparam int ST_BUSY  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   cmp_en = 1'b0;

  can_tx_mailbox_arbiter_if #(.NUM_MB(NMB)) bus ();

  can_tx_mailbox_arbiter #(
    .NUM_MB   (NMB),
    .MAX_RETRY(MR),
    .IFS_WAIT (IFS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: mailbox contents plus where the current launch stands.
  int              m_stage;
  int              m_lock;
  int              m_run;
  logic [NMB-1:0]  m_pend;
  logic [NMB-1:0]  m_done;
  logic [NMB-1:0]  m_fail;
  logic [10:0]     m_id   [NMB];
  logic [63:0]     m_data [NMB];
  int              m_retry[NMB];
  logic            m_start;
  logic [10:0]     m_txid;
  logic [63:0]     m_txdata;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_stage = ST_IDLE; m_lock = 0; m_run = 0;
    m_pend = '0; m_done = '0; m_fail = '0;
    m_start = 1'b0; m_txid = '0; m_txdata = '0;
    for (int i = 0; i < NMB; i++) begin
      m_id[i] = '0; m_data[i] = '0; m_retry[i] = 0;
    end
  endfunction

  function automatic void model_step();
    int st;
    int ld;
    int best;
    int key;
    int best_key;
    st = m_stage;
    ld = -1;
    best = -1;
    best_key = 0;
    m_start = 1'b0; m_done = '0; m_fail = '0;
    case (st)
      ST_IDLE: if (m_pend != '0) m_stage = ST_SEL;
      ST_SEL: begin
        // Priority key: ID first, mailbox index breaks ties.
        for (int i = 0; i < NMB; i++) begin
          key = int'(m_id[i]) * NMB + i;
          if (m_pend[i] && (best < 0 || key < best_key)) begin
            best = i; best_key = key;
          end
        end
        if (best < 0) m_stage = ST_IDLE;
        else begin
          m_lock = best; m_txid = m_id[best]; m_txdata = m_data[best];
          m_run = 0; m_stage = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mb_abort[m_lock] || !m_pend[m_lock]) m_stage = ST_IDLE;
        else if (bus.bus_idle) begin
          if (m_run < IFS) m_run++;
          if (m_run >= IFS) begin m_stage = ST_START; m_start = 1'b1; end
        end else m_run = 0;
      end
      ST_START: m_stage = ST_BUSY;
      ST_BUSY: begin
        if (bus.tx_done) begin
          m_pend[m_lock] = 1'b0; m_retry[m_lock] = 0; m_done[m_lock] = 1'b1;
          m_stage = ST_IDLE;
        end else if (bus.tx_err || bus.tx_arb_lost) begin
          m_stage = ST_IDLE;
`ifdef CAN_TX_ARB_SINGLE_SHOT_EN
          m_pend[m_lock] = 1'b0; m_fail[m_lock] = 1'b1;
`else
          if (bus.tx_err) begin
            m_retry[m_lock]++;
            if (m_retry[m_lock] == MR) begin
              m_pend[m_lock] = 1'b0; m_retry[m_lock] = 0; m_fail[m_lock] = 1'b1;
            end
          end
`endif
        end
      end
      default: m_stage = ST_IDLE;
    endcase
    for (int i = NMB - 1; i >= 0; i--) if (bus.mb_load[i]) ld = i;
    if (ld >= 0 && !(st >= ST_WAIT && ld == m_lock)) begin
      m_id[ld] = bus.mb_id_in; m_data[ld] = bus.mb_data_in;
      m_pend[ld] = 1'b1; m_retry[ld] = 0;
    end
    for (int i = 0; i < NMB; i++) begin
      if (bus.mb_abort[i] && !(st >= ST_START && i == m_lock)) begin
        m_pend[i] = 1'b0; m_retry[i] = 0;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (rst) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("tx_start",   bus.tx_start,   m_start);
      chk("busy",       bus.busy,       m_stage != ST_IDLE);
      chk("tx_id",      bus.tx_id,      m_txid);
      chk("tx_data",    bus.tx_data,    m_txdata);
      chk("mb_pending", bus.mb_pending, m_pend);
      chk("mb_done",    bus.mb_done,    m_done);
      chk("mb_fail",    bus.mb_fail,    m_fail);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic load(input int idx, input logic [10:0] id, input logic [63:0] d);
    bus.mb_load = '0;
    bus.mb_load[idx] = 1'b1;
    bus.mb_id_in = id;
    bus.mb_data_in = d;
    step();
    bus.mb_load = '0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (bus.tx_start !== 1'b1 && lat < 64) begin
      step();
      lat++;
    end
    if (bus.tx_start !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_start: tx_start got 0 expected 1 within 64 cycles");
    end
  endtask

  // kind: 0 = tx_done, 1 = tx_err, 2 = tx_arb_lost; called in the START cycle.
  task automatic result(input int kind);
    step();
    bus.tx_done = (kind == 0);
    bus.tx_err = (kind == 1);
    bus.tx_arb_lost = (kind == 2);
    step();
    bus.tx_done = 1'b0; bus.tx_err = 1'b0; bus.tx_arb_lost = 1'b0;
  endtask

  initial begin
    int lat;
    int r;
    bit pat [6];
    logic [NMB-1:0] ld;
    logic [NMB-1:0] ab;
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    bus.mb_load = '0; bus.mb_id_in = '0; bus.mb_data_in = '0; bus.mb_abort = '0;
    bus.bus_idle = 1'b1; bus.tx_done = 1'b0; bus.tx_err = 1'b0; bus.tx_arb_lost = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("reset_busy", bus.busy, 1'b0);
    chk("reset_tx_id", bus.tx_id, 11'h000);
    chk("reset_pending", bus.mb_pending, 4'b0000);

    // Lowest ID wins and launches IFS_WAIT+2 cycles after the first pending frame.
    load(0, 11'h123, 64'h0123_4567_89AB_CDEF);
    load(2, 11'h055, 64'hFEDC_BA98_7654_3210);
    wait_start(lat);
    chk("t1_latency", lat + 1, 5);
    chk("t1_id", bus.tx_id, 11'h055);
    chk("t1_data", bus.tx_data, 64'hFEDC_BA98_7654_3210);
    result(0);
    chk("t1_done2", bus.mb_done, 4'b0100);
    chk("t1_pend", bus.mb_pending, 4'b0001);
    wait_start(lat);
    chk("t1_id2", bus.tx_id, 11'h123);
    result(0);
    chk("t1_done0", bus.mb_done, 4'b0001);

    // Equal IDs: lower mailbox index first.
    load(3, 11'h200, 64'h3333_3333_3333_3333);
    load(1, 11'h200, 64'h1111_1111_1111_1111);
    wait_start(lat);
    chk("t2_data1", bus.tx_data, 64'h1111_1111_1111_1111);
    result(0);
    chk("t2_done1", bus.mb_done, 4'b0010);
    wait_start(lat);
    chk("t2_data3", bus.tx_data, 64'h3333_3333_3333_3333);
    result(0);
    chk("t2_done3", bus.mb_done, 4'b1000);

    // Error retries until the limit drops the mailbox.
    load(0, 11'h300, 64'hAAAA_5555_AAAA_5555);
`ifdef CAN_TX_ARB_SINGLE_SHOT_EN
    wait_start(lat);
    result(1);
    chk("t3_fail", bus.mb_fail, 4'b0001);
    chk("t3_pend", bus.mb_pending, 4'b0000);
`else
    for (int e = 1; e <= MR; e++) begin
      wait_start(lat);
      result(1);
      chk("t3_fail", bus.mb_fail, (e == MR) ? 4'b0001 : 4'b0000);
      chk("t3_pend", bus.mb_pending, (e == MR) ? 4'b0000 : 4'b0001);
    end
`endif

    // Lost arbitration re-arbitrates against a newer, higher-priority frame.
    load(0, 11'h100, 64'h0000_0000_0000_0100);
    wait_start(lat);
    step();
    load(1, 11'h010, 64'h0000_0000_0000_0010);
    bus.tx_arb_lost = 1'b1;
    step();
    bus.tx_arb_lost = 1'b0;
`ifdef CAN_TX_ARB_SINGLE_SHOT_EN
    chk("t4_fail", bus.mb_fail, 4'b0001);
    chk("t4_pend", bus.mb_pending, 4'b0010);
    wait_start(lat);
    chk("t4_id", bus.tx_id, 11'h010);
    result(0);
    chk("t4_done1", bus.mb_done, 4'b0010);
`else
    chk("t4_pend", bus.mb_pending, 4'b0011);
    wait_start(lat);
    chk("t4_id", bus.tx_id, 11'h010);
    result(0);
    wait_start(lat);
    chk("t4_id2", bus.tx_id, 11'h100);
    result(0);
    chk("t4_done0", bus.mb_done, 4'b0001);
`endif

    // Interframe space needs consecutive idle cycles.
    bus.bus_idle = 1'b0;
    load(2, 11'h0AA, 64'h0000_0000_0000_00AA);
    step();
    step();
    for (int j = 0; j < 6; j++) begin
      bus.bus_idle = pat[j];
      step();
      chk("t5_start", bus.tx_start, j == 5);
    end
    bus.bus_idle = 1'b1;
    result(0);
    chk("t5_done", bus.mb_done, 4'b0100);

    // Reset mid-frame drops everything; a late tx_done is ignored.
    load(0, 11'h7FF, 64'hDEAD_BEEF_CAFE_F00D);
    wait_start(lat);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_id", bus.tx_id, 11'h000);
    chk("t6_data", bus.tx_data, 64'h0);
    chk("t6_pend", bus.mb_pending, 4'b0000);
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
    chk("t6_done", bus.mb_done, 4'b0000);

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      ld = '0;
      ab = '0;
      if ($urandom_range(0, 3) == 0) begin
        ld[$urandom_range(0, NMB - 1)] = 1'b1;
        if ($urandom_range(0, 9) == 0) ld = ld | NMB'($urandom);
      end
      if ($urandom_range(0, 19) == 0) ab[$urandom_range(0, NMB - 1)] = 1'b1;
      bus.mb_load = ld;
      bus.mb_abort = ab;
      bus.mb_id_in = ($urandom_range(0, 1) == 0) ? 11'($urandom_range(0, 7) << 4) : 11'($urandom);
      bus.mb_data_in = {$urandom, $urandom};
      bus.bus_idle = ($urandom_range(0, 4) != 0);
      bus.tx_done = 1'b0; bus.tx_err = 1'b0; bus.tx_arb_lost = 1'b0;
      if (m_stage == ST_BUSY && $urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 9);
        if (r <= 3) bus.tx_done = 1'b1;
        else if (r <= 6) bus.tx_err = 1'b1;
        else if (r <= 8) bus.tx_arb_lost = 1'b1;
        else begin
          bus.tx_done = 1'($urandom_range(0, 1));
          bus.tx_err = 1'($urandom_range(0, 1));
          bus.tx_arb_lost = 1'($urandom_range(0, 1));
        end
      end else if ($urandom_range(0, 99) == 0) begin
        bus.tx_err = 1'b1;
      end
      rst = ($urandom_range(0, 599) == 0);
      step();
    end
    rst = 1'b0;
    bus.mb_load = '0; bus.mb_abort = '0;
    bus.tx_done = 1'b0; bus.tx_err = 1'b0; bus.tx_arb_lost = 1'b0;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/can_tx_mailbox_arbiter.md
Name: can_tx_mailbox_arbiter

Overview:
Holds NUM_MB outgoing CAN standard-frame mailboxes (11-bit ID, 64-bit data).
Picks the pending mailbox with the lowest ID, which matches CAN bus priority, and launches it on the transmit bit engine once the bus has been idle for the interframe space.
Handles lost arbitration, error retry and abort.
Sits between the host/UART side and the baud-rate transmit block, mirroring the receive path.

Parameters:
NUM_MB, 4, number of mailboxes (2..8)
MAX_RETRY, 3, tx_err events tolerated per mailbox before it is dropped (1..15)
IFS_WAIT, 3, consecutive bus_idle cycles required before tx_start

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mb_load  in  NUM_MB  one-hot load strobe; writes mb_id_in/mb_data_in into mailbox i and sets it pending
mb_id_in  in  11  identifier to load
mb_data_in  in  64  payload to load (bit 63 is sent first)
mb_abort  in  NUM_MB  per-mailbox abort request
bus_idle  in  1  bus recessive/idle indication from the bit engine
tx_start  out  1  one-cycle launch pulse to the transmit engine
tx_id  out  11  identifier of the launched frame, stable from tx_start until the frame ends
tx_data  out  64  payload of the launched frame, stable likewise
tx_done  in  1  one-cycle pulse: frame sent and acknowledged
tx_arb_lost  in  1  one-cycle pulse: arbitration lost to another node
tx_err  in  1  one-cycle pulse: bit/ack/stuff error during the frame
mb_pending  out  NUM_MB  mailbox holds an unsent frame
mb_done  out  NUM_MB  one-cycle pulse on successful send
mb_fail  out  NUM_MB  one-cycle pulse when a mailbox is dropped (retry limit reached)
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (sync, rst=1 at clk edge): all outputs 0, tx_id=0, tx_data=0, every mailbox cleared, retry counters 0, state IDLE. Reset mid-frame drops everything and no pulses are emitted.
- All state changes happen on the clk rising edge.
- States: IDLE, SELECT, WAIT_BUS, START, BUSY.
- IDLE: if any mb_pending bit is set, go to SELECT next cycle.
- SELECT (1 cycle):
  - Winner = pending mailbox with the numerically lowest ID; on an ID tie, the lowest index wins.
  - Latch the winner's index (the locked mailbox), tx_id and tx_data; clear the idle counter; go to WAIT_BUS.
  - If nothing is pending (aborted meanwhile), go back to IDLE.
- WAIT_BUS:
  - Idle counter increments while bus_idle=1 and resets to 0 when bus_idle=0.
  - When the counter reaches IFS_WAIT, go to START.
  - If the locked mailbox is aborted, clear it and go to IDLE (no mb_fail).
- START: tx_start=1 for exactly one cycle, then go to BUSY. Latency from pending set to tx_start is at least IFS_WAIT+2 cycles.
- BUSY: wait for a result pulse.
  - tx_done: clear pending and retry counter, pulse mb_done[sel], go to IDLE.
  - tx_arb_lost: pending kept, retry counter unchanged, go to IDLE; the mailbox is re-arbitrated against any newly loaded ones.
  - tx_err: retry counter +1. If it now equals MAX_RETRY, clear pending, reset the counter and pulse mb_fail[sel]. Go to IDLE.
  - Simultaneous pulses: priority is tx_done > tx_err > tx_arb_lost.
- Loads:
  - Accepted in any state for unlocked mailboxes.
  - A load to the locked mailbox during WAIT_BUS/START/BUSY is ignored.
  - A load to a pending unlocked mailbox overwrites it and resets its retry counter.
  - mb_load is assumed one-hot. If several bits are set, only the lowest index is written.
- Aborts:
  - An abort to an unlocked mailbox clears it next cycle; no pulse is emitted.
  - An abort to the locked mailbox in START/BUSY is ignored, because a frame cannot be stopped.
  - Load and abort to the same mailbox in the same cycle: abort wins.
- Widths: retry counters are 4 bits. The idle counter saturates at IFS_WAIT.

Optional Feature:
CAN_TX_ARB_SINGLE_SHOT_EN.
- Defined: one-shot mode. Any tx_err or tx_arb_lost clears the locked mailbox and pulses mb_fail[sel]; no retries, and retry counters are not implemented.
- Undefined: retry behaviour exactly as described above.

Test Plan:
- Load mb0 ID 0x123 and mb2 ID 0x055, hold bus_idle=1 → tx_start with tx_id=0x055 at IFS_WAIT+2 cycles; after tx_done, mb_done[2] pulses, then tx_id=0x123 launches, then mb_done[0].
- Load mb1 and mb3 both with ID 0x200 → mb1 launches first.
- Load mb0 (ID 0x300), BUSY, inject tx_err three times across retries → third error pulses mb_fail[0] and mb_pending=0; with the macro defined, the first error drops it.
- mb0 ID 0x100 in BUSY, load mb1 ID 0x010, inject tx_arb_lost → next tx_start carries 0x010, and mb0 is sent afterwards.
- bus_idle toggles 1,1,0,1,1,1 in WAIT_BUS → tx_start is delayed until three consecutive idle cycles.
- Assert rst while in BUSY → next cycle all outputs 0, state IDLE, and later tx_done pulses are ignored.
